// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised inter-stage pipeline register:
// default bundle widths, control-bundle field map and the saturating counter helper.
package pipe_pkg;

    localparam int CTRL_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 160;
    localparam int MAX_CNT_W      = 32;

    // Control bundle field map (bit offsets inside ctrl)
    localparam int MEMREAD_B    = 0;
    localparam int MEMWRITE_B   = 1;
    localparam int MEMTOREG_LSB = 2;
    localparam int MEMTOREG_W   = 2;
    localparam int REGWRITE_B   = 4;
    localparam int ALUOP_LSB    = 5;
    localparam int ALUOP_W      = 2;
    localparam int ALUSRC_B     = 7;

    // Increment cnt by one unless it already holds the all-ones value for a width-bit counter.
    function automatic logic [MAX_CNT_W-1:0] cnt_sat_inc(input logic [MAX_CNT_W-1:0] cnt,
                                                         input int unsigned         width);
        logic [MAX_CNT_W-1:0] max_val;
        max_val = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - width);
        return (cnt >= max_val) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One retiming slot of the pipeline register: valid + control + datapath bundle
// with reset > flush > stall > load priority.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = CTRL_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              load_valid,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every slot samples
    // its neighbour's pre-edge value and the chain shifts by exactly one per edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (!stall) begin
            valid <= load_valid;
            ctrl  <= load_valid ? load_ctrl : '0;
        end
    end

    if (CLEAR_DATA) begin : g_clear_data
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                data <= '0;
            end else if (!stall) begin
                data <= load_data;
            end
        end
    end else begin : g_keep_data
        // NOTE: the wide datapath flops are deliberately left without reset; valid and
        // ctrl already mark the slot as a bubble, so stale data is harmless downstream.
        always_ff @(posedge clk) begin
            if (!rst && !flush && !stall) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: STAGES chained slots with stall/flush
// control and saturating stall/flush/bubble counters for performance debug.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = CTRL_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int STAGES     = 1,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("pipe_stage_reg: STAGES=%0d is outside the legal range 1..4", STAGES);
    end

    if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W=%0d is outside the legal range 1..%0d", CNT_W, MAX_CNT_W);
    end

    logic [STAGES-1:0]             slot_valid;
    logic [STAGES-1:0][CTRL_W-1:0] slot_ctrl;
    logic [STAGES-1:0][DATA_W-1:0] slot_data;

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        logic              in_valid;
        logic [CTRL_W-1:0] in_ctrl;
        logic [DATA_W-1:0] in_data;

        if (k == 0) begin : g_head
            assign in_valid = valid_i;
            assign in_ctrl  = ctrl_i;
            assign in_data  = data_i;
        end else begin : g_chain
            assign in_valid = slot_valid[k-1];
            assign in_ctrl  = slot_ctrl[k-1];
            assign in_data  = slot_data[k-1];
        end

        pipe_slot #(
            .CTRL_W     (CTRL_W),
            .DATA_W     (DATA_W),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush_i),
            .stall      (stall_i),
            .load_valid (in_valid),
            .load_ctrl  (in_ctrl),
            .load_data  (in_data),
            .valid      (slot_valid[k]),
            .ctrl       (slot_ctrl[k]),
            .data       (slot_data[k])
        );
    end

    assign valid_o = slot_valid[STAGES-1];
    assign data_o  = slot_data[STAGES-1];
    // Second guard: a bubble can never present a live control word downstream.
    assign ctrl_o  = valid_o ? slot_ctrl[STAGES-1] : '0;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // A flush overrides a simultaneous stall, so such a cycle counts only as a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_i && !flush_i) begin
                stall_cnt <= CNT_W'(cnt_sat_inc(MAX_CNT_W'(stall_cnt), CNT_W));
            end
            if (flush_i) begin
                flush_cnt <= CNT_W'(cnt_sat_inc(MAX_CNT_W'(flush_cnt), CNT_W));
            end
            if (!valid_o) begin
                bubble_cnt <= CNT_W'(cnt_sat_inc(MAX_CNT_W'(bubble_cnt), CNT_W));
            end
        end
    end

    assign stall_cnt_o  = stall_cnt;
    assign flush_cnt_o  = flush_cnt;
    assign bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: two configurations driven in lockstep
// and compared against a record-shifting reference model of the pipeline.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = 8;
    localparam int DW = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          stall_i;
    logic          flush_i;
    logic          valid_i;
    logic [CW-1:0] ctrl_i;
    logic [DW-1:0] data_i;

    // Configuration A: 2 slots, data cleared, 16-bit counters
    logic          valid_a;
    logic [CW-1:0] ctrl_a;
    logic [DW-1:0] data_a;
    logic [15:0]   stall_cnt_a, flush_cnt_a, bubble_cnt_a;

    // Configuration B: 3 slots, data kept, 4-bit counters
    logic          valid_b;
    logic [CW-1:0] ctrl_b;
    logic [DW-1:0] data_b;
    logic [3:0]    stall_cnt_b, flush_cnt_b, bubble_cnt_b;

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .STAGES(2), .CLEAR_DATA(1'b1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid_a), .ctrl_o(ctrl_a), .data_o(data_a),
        .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a), .bubble_cnt_o(bubble_cnt_a)
    );

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .STAGES(3), .CLEAR_DATA(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid_b), .ctrl_o(ctrl_b), .data_o(data_b),
        .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b), .bubble_cnt_o(bubble_cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each configuration is a list of in-flight instruction records.
    typedef struct packed {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } slot_t;

    slot_t ms [2][4];
    int    mstages [2] = '{2, 3};
    int    mmax    [2] = '{65535, 15};
    bit    mclr    [2] = '{1'b1, 1'b0};
    int    mstall  [2];
    int    mflush  [2];
    int    mbub    [2];

    function automatic int sat_add(input int v, input int max);
        return (v < max) ? v + 1 : max;
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int n;
            n = mstages[m];
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    ms[m][k].valid = 1'b0;
                    ms[m][k].ctrl  = '0;
                    if (mclr[m]) ms[m][k].data = '0;
                end
                mstall[m] = 0;
                mflush[m] = 0;
                mbub[m]   = 0;
            end else begin
                if (stall_i && !flush_i) mstall[m] = sat_add(mstall[m], mmax[m]);
                if (flush_i)             mflush[m] = sat_add(mflush[m], mmax[m]);
                if (!ms[m][n-1].valid)   mbub[m]   = sat_add(mbub[m], mmax[m]);
                if (flush_i) begin
                    for (int k = 0; k < 4; k++) begin
                        ms[m][k].valid = 1'b0;
                        ms[m][k].ctrl  = '0;
                        if (mclr[m]) ms[m][k].data = '0;
                    end
                end else if (!stall_i) begin
                    for (int k = n - 1; k > 0; k--) ms[m][k] = ms[m][k-1];
                    ms[m][0].valid = valid_i;
                    ms[m][0].ctrl  = valid_i ? ctrl_i : '0;
                    ms[m][0].data  = data_i;
                end
            end
        end
    endtask

    // Advance one clock: model follows the same inputs the DUTs sample, outputs settle by #1.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst     = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ctrl_i  = CW'($urandom);
        data_i  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        idle_inputs();
        rst     = 1'b1;
        valid_i = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        stall_i = 1'($urandom);
        flush_i = 1'($urandom);
        valid_i = 1'b1;
        ctrl_i  = CW'($urandom) | 8'h01;
        data_i  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        step();
        step();
        n_checks++;
        if (valid_a !== 1'b0 || ctrl_a !== '0) begin
            n_fail++;
            $display("FAIL reset_a_valid_ctrl: got v=%b c=%h, expected v=0 c=00", valid_a, ctrl_a);
        end
        n_checks++;
        if (data_a !== '0) begin
            n_fail++;
            $display("FAIL reset_a_data: got %h, expected 0", data_a);
        end
        n_checks++;
        if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0 || bubble_cnt_a !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_a_counters: got s=%0d f=%0d b=%0d, expected 0 0 0",
                     stall_cnt_a, flush_cnt_a, bubble_cnt_a);
        end
        n_checks++;
        if (valid_b !== 1'b0 || ctrl_b !== '0 ||
            stall_cnt_b !== 4'd0 || flush_cnt_b !== 4'd0 || bubble_cnt_b !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b c=%h s=%0d f=%0d b=%0d, expected all 0",
                     valid_b, ctrl_b, stall_cnt_b, flush_cnt_b, bubble_cnt_b);
        end
        idle_inputs();
    endtask

    task automatic test_latency();
        do_reset();
        valid_i = 1'b1;
        ctrl_i  = 8'hA5;
        data_i  = DW'(16'h1234);
        step();
        valid_i = 1'b0;
        ctrl_i  = CW'($urandom);
        data_i  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        n_checks++;
        if (valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: valid_o got %b after 1 edge, expected 0", valid_a);
        end
        step();
        n_checks++;
        if (valid_a !== 1'b1 || ctrl_a !== 8'hA5 || data_a !== DW'(16'h1234)) begin
            n_fail++;
            $display("FAIL latency_arrive: got v=%b c=%h d=%h, expected v=1 c=a5 d=1234",
                     valid_a, ctrl_a, data_a);
        end
        step();
        n_checks++;
        if (valid_a !== 1'b0 || ctrl_a !== '0) begin
            n_fail++;
            $display("FAIL latency_one_cycle: got v=%b c=%h, expected v=0 c=00", valid_a, ctrl_a);
        end
        n_checks++;
        if (valid_b !== 1'b1 || ctrl_b !== 8'hA5 || data_b !== DW'(16'h1234)) begin
            n_fail++;
            $display("FAIL latency_3stage: got v=%b c=%h d=%h, expected v=1 c=a5 d=1234",
                     valid_b, ctrl_b, data_b);
        end
        step();
        n_checks++;
        if (valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_3stage_gone: valid_o got %b, expected 0", valid_b);
        end
    endtask

    task automatic test_stall();
        slot_t v [3];
        for (int i = 0; i < 3; i++) begin
            v[i].valid = 1'b1;
            v[i].ctrl  = CW'($urandom) | 8'h80;
            v[i].data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1;
            ctrl_i  = v[i].ctrl;
            data_i  = v[i].data;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            stall_i = 1'b1;
            valid_i = 1'($urandom);
            ctrl_i  = CW'($urandom);
            data_i  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            step();
            n_checks++;
            if (valid_a !== 1'b1 || ctrl_a !== v[0].ctrl || data_a !== v[0].data) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got v=%b c=%h d=%h, expected v=1 c=%h d=%h",
                         i, valid_a, ctrl_a, data_a, v[0].ctrl, v[0].data);
            end
        end
        n_checks++;
        if (stall_cnt_a !== 16'd3 || stall_cnt_b !== 4'd3) begin
            n_fail++;
            $display("FAIL stall_count: got a=%0d b=%0d, expected 3", stall_cnt_a, stall_cnt_b);
        end
        stall_i = 1'b0;
        valid_i = 1'b1;
        ctrl_i  = v[2].ctrl;
        data_i  = v[2].data;
        step();
        n_checks++;
        if (valid_a !== 1'b1 || ctrl_a !== v[1].ctrl || data_a !== v[1].data) begin
            n_fail++;
            $display("FAIL stall_resume: got c=%h d=%h, expected c=%h d=%h",
                     ctrl_a, data_a, v[1].ctrl, v[1].data);
        end
        valid_i = 1'b0;
        step();
        n_checks++;
        if (valid_a !== 1'b1 || ctrl_a !== v[2].ctrl || data_a !== v[2].data) begin
            n_fail++;
            $display("FAIL stall_resume_next: got c=%h d=%h, expected c=%h d=%h",
                     ctrl_a, data_a, v[2].ctrl, v[2].data);
        end
    endtask

    task automatic test_flush_with_stall();
        logic [DW-1:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            ctrl_i  = 8'hFF;
            data_i  = d[i];
            step();
        end
        n_checks++;
        if (valid_b !== 1'b1 || ctrl_b !== 8'hFF || data_b !== d[0]) begin
            n_fail++;
            $display("FAIL flush_fill: got v=%b c=%h d=%h, expected v=1 c=ff d=%h",
                     valid_b, ctrl_b, data_b, d[0]);
        end
        flush_i = 1'b1;
        stall_i = 1'b1;
        step();
        n_checks++;
        if (valid_a !== 1'b0 || ctrl_a !== '0 || data_a !== '0) begin
            n_fail++;
            $display("FAIL flush_a_state: got v=%b c=%h d=%h, expected all 0", valid_a, ctrl_a, data_a);
        end
        n_checks++;
        if (flush_cnt_a !== 16'd1 || stall_cnt_a !== 16'd0 ||
            flush_cnt_b !== 4'd1 || stall_cnt_b !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_counts: got fa=%0d sa=%0d fb=%0d sb=%0d, expected 1 0 1 0",
                     flush_cnt_a, stall_cnt_a, flush_cnt_b, stall_cnt_b);
        end
        n_checks++;
        if (valid_b !== 1'b0 || ctrl_b !== '0 || data_b !== d[0]) begin
            n_fail++;
            $display("FAIL flush_b_keep_data: got v=%b c=%h d=%h, expected v=0 c=00 d=%h",
                     valid_b, ctrl_b, data_b, d[0]);
        end
        idle_inputs();
        step();
        n_checks++;
        if (valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_discard_input: valid_o got %b, expected 0", valid_a);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        stall_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i >= 15) begin
                n_checks++;
                if (stall_cnt_b !== 4'd15) begin
                    n_fail++;
                    $display("FAIL stall_saturate cycle %0d: got %0d, expected 15", i, stall_cnt_b);
                end
            end
        end
        n_checks++;
        if (stall_cnt_a !== 16'd20 || bubble_cnt_a !== 16'd20 || bubble_cnt_b !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate_others: got sa=%0d ba=%0d bb=%0d, expected 20 20 15",
                     stall_cnt_a, bubble_cnt_a, bubble_cnt_b);
        end
        idle_inputs();
    endtask

    task automatic test_reset_during_flush();
        do_reset();
        valid_i = 1'b1;
        ctrl_i  = 8'h3C;
        step();
        step();
        flush_i = 1'b1;
        step();
        rst     = 1'b1;
        flush_i = 1'b1;
        stall_i = 1'b1;
        valid_i = 1'b1;
        step();
        n_checks++;
        if (valid_a !== 1'b0 || ctrl_a !== '0 || data_a !== '0 || valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flush_state: got va=%b ca=%h da=%h vb=%b, expected all 0",
                     valid_a, ctrl_a, data_a, valid_b);
        end
        n_checks++;
        if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0 || bubble_cnt_a !== 16'd0 ||
            flush_cnt_b !== 4'd0 || bubble_cnt_b !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_flush_counters: got sa=%0d fa=%0d ba=%0d fb=%0d bb=%0d, expected 0",
                     stall_cnt_a, flush_cnt_a, bubble_cnt_a, flush_cnt_b, bubble_cnt_b);
        end
        idle_inputs();
        step();
        n_checks++;
        if (bubble_cnt_a !== 16'd1 || flush_cnt_a !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_flush_after: got ba=%0d fa=%0d, expected 1 0", bubble_cnt_a, flush_cnt_a);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst     = ($urandom_range(0, 49) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            stall_i = ($urandom_range(0, 3) == 0);
            valid_i = 1'($urandom);
            ctrl_i  = CW'($urandom);
            data_i  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            step();
            n_checks++;
            if (valid_a !== ms[0][1].valid || ctrl_a !== ms[0][1].ctrl || data_a !== ms[0][1].data ||
                stall_cnt_a !== 16'(mstall[0]) || flush_cnt_a !== 16'(mflush[0]) ||
                bubble_cnt_a !== 16'(mbub[0])) begin
                n_fail++;
                $display("FAIL random_a cyc %0d: got v=%b c=%h d=%h s=%0d f=%0d b=%0d, expected v=%b c=%h d=%h s=%0d f=%0d b=%0d",
                         cyc, valid_a, ctrl_a, data_a, stall_cnt_a, flush_cnt_a, bubble_cnt_a,
                         ms[0][1].valid, ms[0][1].ctrl, ms[0][1].data, mstall[0], mflush[0], mbub[0]);
            end
            n_checks++;
            if (valid_b !== ms[1][2].valid || ctrl_b !== ms[1][2].ctrl ||
                (ms[1][2].valid && data_b !== ms[1][2].data) ||
                stall_cnt_b !== 4'(mstall[1]) || flush_cnt_b !== 4'(mflush[1]) ||
                bubble_cnt_b !== 4'(mbub[1])) begin
                n_fail++;
                $display("FAIL random_b cyc %0d: got v=%b c=%h d=%h s=%0d f=%0d b=%0d, expected v=%b c=%h d=%h s=%0d f=%0d b=%0d",
                         cyc, valid_b, ctrl_b, data_b, stall_cnt_b, flush_cnt_b, bubble_cnt_b,
                         ms[1][2].valid, ms[1][2].ctrl, ms[1][2].data, mstall[1], mflush[1], mbub[1]);
            end
            n_checks++;
            if (!valid_a && (ctrl_a[MEMWRITE_B] || ctrl_a[REGWRITE_B])) begin
                n_fail++;
                $display("FAIL random_bubble_guard cyc %0d: bubble ctrl got %h, expected memWrite=0 regWrite=0",
                         cyc, ctrl_a);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_latency();
        test_stall();
        test_flush_with_stall();
        test_saturation();
        test_reset_during_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
